router_fsm: RTL and testbench
=============================

# router_fsm

Packet-level control state machine for the 1x3 router input side. Decodes the header address, sequences header/payload/parity loading into the register stage, stalls on destination FIFO full, and produces the write-enable request consumed by the synchronizer. Sits directly upstream of the synchronizer: its `write_enb_reg` and `detect_add` feed the synchronizer, and it consumes the synchronizer's `fifo_full` and `soft_reset_*`.

## Interface
Parameters:
- `ADDR_W`, 2: header address field width; address values 0..2 valid, 3 invalid.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `pkt_valid`  in  1  source drives a valid packet byte.
- `data_in`  in  ADDR_W  header address bits, sampled in DECODE_ADDRESS only.
- `fifo_full`  in  1  selected destination FIFO full (from synchronizer).
- `fifo_empty_0/1/2`  in  1 each  per-FIFO empty flags.
- `soft_reset_0/1/2`  in  1 each  per-FIFO timeout reset (from synchronizer).
- `parity_done`  in  1  register stage has captured the parity byte.
- `low_pkt_valid`  in  1  pkt_valid fell while the last payload byte was held off.
- `detect_add`  out  1  in DECODE_ADDRESS.
- `lfd_state`, `ld_state`, `laf_state`, `full_state`  out  1 each  one-hot state indicators.
- `write_enb_reg`  out  1  request FIFO write this cycle.
- `rst_int_reg`  out  1  in CHECK_PARITY_ERROR.
- `busy`  out  1  source must hold its byte.
- `drop_cnt`  out  8  invalid-address header count (see Configuration).

## Operation
- States: DECODE_ADDRESS (reset), LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- DECODE_ADDRESS: if `pkt_valid` and `data_in`!=3, latch `addr_q`<=`data_in`; go LOAD_FIRST_DATA if `fifo_empty_[data_in]`, else WAIT_TILL_EMPTY. Otherwise stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA: `fifo_full` -> FIFO_FULL_STATE; else `!pkt_valid` -> LOAD_PARITY; else stay. `fifo_full` has priority.
- FIFO_FULL_STATE: stay while `fifo_full`; else LOAD_AFTER_FULL.
- LOAD_AFTER_FULL: `parity_done` -> DECODE_ADDRESS; else `low_pkt_valid` -> LOAD_PARITY; else LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: `fifo_full` -> FIFO_FULL_STATE; else DECODE_ADDRESS.
- WAIT_TILL_EMPTY: `fifo_empty_[addr_q]` -> LOAD_FIRST_DATA; else stay.
- Soft reset: `soft_reset_[addr_q]` high in any state other than DECODE_ADDRESS -> DECODE_ADDRESS next cycle; overrides every other transition. Soft resets for non-selected FIFOs ignored.
- Outputs decoded from registered state (Moore): `write_enb_reg` = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL; `busy` = every state except DECODE_ADDRESS and LOAD_DATA.

## Timing
- Reset: state=DECODE_ADDRESS, `addr_q`=0, `drop_cnt`=0; so `detect_add`=1, all other outputs 0.
- Reset deassertion mid-packet: FSM restarts in DECODE_ADDRESS; partial packet abandoned.
- Header accepted edge N: LOAD_FIRST_DATA during cycle N+1, `write_enb_reg` first high in cycle N+2 (LOAD_DATA).
- Outputs change only after clock edges; no input-to-output combinational path.
- Minimum packet (header, 1 payload, parity): DECODE -> LFD -> LD -> LP -> CPE -> DECODE, 5 cycles.

## Configuration
- `ROUTER_FSM_DROP_CNT_EN` defined: each cycle in DECODE_ADDRESS with `pkt_valid` and `data_in`==3 increments `drop_cnt`, saturating at 255.
- Not defined: no counter logic; `drop_cnt` tied to 0. State behaviour identical in both builds.

## Structure
- Shared package `router_pkg`: state enum typedef, `ADDR_INVALID`=2'd3 constant, FIFO count (3).
- No sub-module; next-state, output decode and optional counter stay in one module.

## Test plan
- Addr 1, FIFO 1 empty, 3 payload bytes then `pkt_valid`=0 -> states DECODE,LFD,LD,LD,LD,LP,CPE,DECODE; `write_enb_reg` high 4 cycles.
- Addr 2 with `fifo_empty_2`=0 for 5 cycles -> WAIT_TILL_EMPTY 5 cycles, `busy`=1, then LFD on first edge after empty rises.
- `fifo_full`=1 in LD for 4 cycles, `parity_done`=0, `low_pkt_valid`=0 -> FFS x4, LAF, LD; `full_state`=1 only during FFS.
- `soft_reset_0` pulse while in FFS with `addr_q`=0 -> DECODE next cycle; `soft_reset_1` pulse in same situation -> no effect.
- Header `data_in`=3 with `pkt_valid` for 300 cycles -> remains DECODE; `drop_cnt`=255 with macro, 0 without.
- Async `resetn` low during LD -> immediately DECODE, `write_enb_reg`=0, `detect_add`=1.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router input-side control.
// State encoding, invalid header address and FIFO count.
package router_pkg;

  localparam int FIFO_N = 3;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  // Pick one per-FIFO flag by address; the invalid address selects nothing.
  function automatic logic fifo_sel(
    input logic [FIFO_N-1:0] v,
    input logic [1:0]        a
  );
    logic r;
    r = 1'b0;
    case (a)
      2'd0:    r = v[0];
      2'd1:    r = v[1];
      2'd2:    r = v[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet control FSM for the 1x3 router input side.
// Optional invalid-header counter: define ROUTER_FSM_DROP_CNT_EN.
module router_fsm
  import router_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [FIFO_N-1:0] empty_v;
  logic [FIFO_N-1:0] sreset_v;
  logic              hdr_ok;
  logic              hdr_bad;
  logic              in_dec;
  logic              sreset_sel;

  assign empty_v  = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign sreset_v = {soft_reset_2, soft_reset_1, soft_reset_0};

  assign in_dec  = (state == DECODE_ADDRESS);
  assign hdr_bad = in_dec && pkt_valid
                && (data_in == ADDR_W'(ADDR_INVALID));
  assign hdr_ok  = in_dec && pkt_valid
                && (data_in != ADDR_W'(ADDR_INVALID));

  assign sreset_sel = fifo_sel(sreset_v, 2'(addr_q));

  // State register and header address latch
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= DECODE_ADDRESS;
      addr_q <= '0;
    end else begin
      state <= state_nx;
      if (hdr_ok)
        addr_q <= data_in;
    end
  end

  // Next-state; selected-FIFO soft reset overrides everything
  always_comb begin
    state_nx = state;
    if (!in_dec && sreset_sel) begin
      state_nx = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (hdr_ok)
            state_nx = fifo_sel(empty_v, 2'(data_in))
                     ? LOAD_FIRST_DATA
                     : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA:
          state_nx = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)
            state_nx = FIFO_FULL_STATE;
          else if (!pkt_valid)
            state_nx = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full)
            state_nx = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)
            state_nx = DECODE_ADDRESS;
          else if (low_pkt_valid)
            state_nx = LOAD_PARITY;
          else
            state_nx = LOAD_DATA;
        end
        LOAD_PARITY:
          state_nx = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_nx = fifo_full ? FIFO_FULL_STATE
                               : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (fifo_sel(empty_v, 2'(addr_q)))
            state_nx = LOAD_FIRST_DATA;
        end
        default:
          state_nx = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode from the registered state
  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    write_enb_reg = (state == LOAD_DATA)
                 || (state == LOAD_PARITY)
                 || (state == LOAD_AFTER_FULL);
    busy          = !((state == DECODE_ADDRESS)
                 ||   (state == LOAD_DATA));
  end

`ifdef ROUTER_FSM_DROP_CNT_EN
  logic [7:0] drop_q;

  // Saturating count of invalid-address headers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      drop_q <= '0;
    else if (hdr_bad && (drop_q != 8'hff))
      drop_q <= drop_q + 8'd1;
  end

  assign drop_cnt = drop_q;
`else
  logic unused_bad;
  assign unused_bad = hdr_bad;
  assign drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm.
// Directed scenarios plus randomized traffic against a reference model.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, write_enb_reg, rst_int_reg, busy;
  logic [7:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  router_fsm #(.ADDR_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0),
    .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0),
    .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2),
    .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state),
    .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phase names of a packet, not the RTL encoding
  typedef enum int {
    P_IDLE, P_FIRST, P_BODY, P_STALL,
    P_RESUME, P_PAR, P_CHK, P_WAIT
  } phase_t;

  phase_t m_ph;
  int     m_addr;
  int     m_drop;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_outs();
    logic [7:0] o;
    o[7] = (m_ph == P_IDLE);
    o[6] = (m_ph == P_FIRST);
    o[5] = (m_ph == P_BODY);
    o[4] = (m_ph == P_RESUME);
    o[3] = (m_ph == P_STALL);
    o[2] = (m_ph == P_BODY) || (m_ph == P_PAR)
        || (m_ph == P_RESUME);
    o[1] = (m_ph == P_CHK);
    o[0] = (m_ph != P_IDLE) && (m_ph != P_BODY);
    return o;
  endfunction

  function automatic logic [7:0] dut_outs();
    return {detect_add, lfd_state, ld_state, laf_state,
            full_state, write_enb_reg, rst_int_reg, busy};
  endfunction

  function automatic int m_drop_exp();
`ifdef ROUTER_FSM_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  task automatic m_reset();
    m_ph = P_IDLE;
    m_addr = 0;
    m_drop = 0;
  endtask

  task automatic m_step();
    logic [2:0] emp;
    logic [2:0] sr;
    emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    sr  = {soft_reset_2, soft_reset_1, soft_reset_0};
    if (m_ph != P_IDLE && sr[m_addr]) begin
      m_ph = P_IDLE;
      return;
    end
    case (m_ph)
      P_IDLE: begin
        if (pkt_valid && data_in == 2'd3) begin
          if (m_drop < 255) m_drop++;
        end else if (pkt_valid) begin
          m_addr = int'(data_in);
          m_ph = emp[m_addr] ? P_FIRST : P_WAIT;
        end
      end
      P_FIRST:  m_ph = P_BODY;
      P_BODY:
        if (fifo_full) m_ph = P_STALL;
        else if (!pkt_valid) m_ph = P_PAR;
      P_STALL:  if (!fifo_full) m_ph = P_RESUME;
      P_RESUME:
        if (parity_done) m_ph = P_IDLE;
        else if (low_pkt_valid) m_ph = P_PAR;
        else m_ph = P_BODY;
      P_PAR:    m_ph = P_CHK;
      P_CHK:    m_ph = fifo_full ? P_STALL : P_IDLE;
      P_WAIT:   if (emp[m_addr]) m_ph = P_FIRST;
      default:  m_ph = P_IDLE;
    endcase
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; data_in = 0; fifo_full = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    parity_done = 0; low_pkt_valid = 0;
  endtask

  // One clock: advance model, then compare after the edge
  task automatic tick(input string tag);
    @(posedge clk);
    m_step();
    #1;
    check({tag, ".outs"}, 32'(dut_outs()), 32'(m_outs()));
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    m_reset();
    @(posedge clk);
    #1;
    check("rst.outs", 32'(dut_outs()), 32'h80);
    check("rst.drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    resetn = 1;
  endtask

  int cnt;

  initial begin
    idle_inputs();
    do_reset();

    // Addr 1, three payload bytes, then pkt_valid drops
    pkt_valid = 1; data_in = 2'd1;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) pkt_valid = 0;
      tick("pkt1");
      if (i == 0) check("pkt1.lfd", 32'(lfd_state), 32'd1);
      if (i == 1) check("pkt1.ld", 32'(ld_state), 32'd1);
      if (i == 5) check("pkt1.cpe", 32'(rst_int_reg), 32'd1);
      cnt += int'(write_enb_reg);
    end
    check("pkt1.wecnt", 32'(cnt), 32'd4);
    check("pkt1.dec", 32'(detect_add), 32'd1);

    // Addr 2, FIFO 2 busy for five cycles
    pkt_valid = 1; data_in = 2'd2; fifo_empty_2 = 0;
    tick("wait");
    pkt_valid = 0;
    cnt = int'(busy);
    for (int i = 0; i < 4; i++) begin
      tick("wait");
      cnt += int'(busy);
    end
    check("wait.busy", 32'(cnt), 32'd5);
    fifo_empty_2 = 1;
    tick("wait");
    check("wait.lfd", 32'(lfd_state), 32'd1);

    // Stall on full inside the body
    pkt_valid = 1;
    tick("full");
    fifo_full = 1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick("full");
      cnt += int'(full_state);
    end
    check("full.cnt", 32'(cnt), 32'd4);
    fifo_full = 0;
    tick("full");
    check("full.laf", 32'(laf_state), 32'd1);
    check("full.laf_fs", 32'(full_state), 32'd0);
    tick("full");
    check("full.ld", 32'(ld_state), 32'd1);

    // Soft reset: only the selected FIFO counts
    do_reset();
    pkt_valid = 1; data_in = 2'd0;
    tick("srst"); tick("srst");
    fifo_full = 1;
    tick("srst");
    check("srst.ffs", 32'(full_state), 32'd1);
    soft_reset_1 = 1;
    tick("srst");
    check("srst.other", 32'(full_state), 32'd1);
    soft_reset_1 = 0; soft_reset_0 = 1;
    tick("srst");
    check("srst.sel", 32'(detect_add), 32'd1);
    soft_reset_0 = 0; fifo_full = 0; pkt_valid = 0;
    tick("srst");

    // Invalid header held for 300 cycles
    pkt_valid = 1; data_in = 2'd3;
    for (int i = 0; i < 300; i++) tick("drop");
    check("drop.dec", 32'(detect_add), 32'd1);
`ifdef ROUTER_FSM_DROP_CNT_EN
    check("drop.cnt", 32'(drop_cnt), 32'd255);
`else
    check("drop.cnt", 32'(drop_cnt), 32'd0);
`endif

    // Asynchronous reset while loading data
    idle_inputs();
    pkt_valid = 1; data_in = 2'd0;
    tick("arst"); tick("arst");
    check("arst.ld", 32'(ld_state), 32'd1);
    #2;
    resetn = 0;
    m_reset();
    #1;
    check("arst.we", 32'(write_enb_reg), 32'd0);
    check("arst.dec", 32'(detect_add), 32'd1);
    @(negedge clk);
    resetn = 1;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty_0  = ($urandom_range(0, 2) != 0);
      fifo_empty_1  = ($urandom_range(0, 2) != 0);
      fifo_empty_2  = ($urandom_range(0, 2) != 0);
      soft_reset_0  = ($urandom_range(0, 30) == 0);
      soft_reset_1  = ($urandom_range(0, 30) == 0);
      soft_reset_2  = ($urandom_range(0, 30) == 0);
      parity_done   = ($urandom_range(0, 4) == 0);
      low_pkt_valid = ($urandom_range(0, 4) == 0);
      tick("rnd");
      if (i % 16 == 0)
        check("rnd.drop", 32'(drop_cnt), 32'(m_drop_exp()));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
